// File: rtl/alu_sequencer.sv
// Register-file sequencer that drives an external combinational ALU: accept, issue, write back.
// Optional sticky overflow flag output is enabled by defining ALU_SEQUENCER_STICKY_V_EN.
module alu_sequencer #(
   parameter int N_BITS   = 32,
   parameter int RF_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [2:0]        ld_addr,
   input  logic [N_BITS-1:0] ld_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_fs,
   input  logic [2:0]        cmd_ra,
   input  logic [2:0]        cmd_rb,
   input  logic [2:0]        cmd_rd,
   output logic [N_BITS-1:0] alu_a,
   output logic [N_BITS-1:0] alu_b,
   output logic              alu_cin,
   output logic [3:0]        alu_fs,
   input  logic [N_BITS-1:0] alu_y,
   input  logic              alu_n,
   input  logic              alu_c,
   input  logic              alu_v,
   input  logic              alu_z,
   output logic              res_valid,
   output logic [N_BITS-1:0] res_data,
   output logic [3:0]        flags
`ifdef ALU_SEQUENCER_STICKY_V_EN
   ,
   output logic              sticky_v
`endif
);

   localparam logic [3:0] FS_ZERO = 4'b1001;

   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

   state_t              state_q, state_d;
   logic                accept;
   logic                wb;
   logic [N_BITS-1:0]   rf_q [RF_DEPTH];
   logic [2:0]          rd_q;
   logic [N_BITS-1:0]   alu_a_q, alu_b_q, res_data_q;
   logic [3:0]          alu_fs_q, flags_q;
   logic                alu_cin_q, res_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE:   state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign wb = (state_q == WB);

   // Entry 0 is never written, so it reads as zero without a read-side mux.
   // WB write comes after the load so it wins on a same-register collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
         rd_q        <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_fs_q    <= FS_ZERO;
         alu_cin_q   <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         flags_q     <= '0;
      end else begin
         res_valid_q <= wb;
         if (ld_valid && ld_addr != 3'd0) rf_q[ld_addr] <= ld_data;
         if (accept) begin
            alu_a_q   <= rf_q[cmd_ra];
            alu_b_q   <= rf_q[cmd_rb];
            alu_fs_q  <= cmd_fs;
            alu_cin_q <= flags_q[2];
            rd_q      <= cmd_rd;
         end
         if (wb) begin
            if (rd_q != 3'd0) rf_q[rd_q] <= alu_y;
            res_data_q <= alu_y;
            flags_q    <= {alu_n, alu_c, alu_v, alu_z};
         end
      end
   end

`ifdef ALU_SEQUENCER_STICKY_V_EN
   logic sticky_q;

   // A zero op reaching WB clears the sticky bit even if it reports overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (wb) begin
         if (alu_fs_q == FS_ZERO) sticky_q <= 1'b0;
         else if (alu_v)          sticky_q <= 1'b1;
      end
   end

   assign sticky_v = sticky_q;
`endif

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_fs    = alu_fs_q;
   assign alu_cin   = alu_cin_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign flags     = flags_q;

endmodule
